// File: rtl/tis_any_writer_pkg.sv
// Shared link definitions for the TIS-100 node links: widths, link bit
// positions, direction codes, value range, FSM state type and small helpers
// to clamp a value and pack it onto a link bus.
package tis_any_writer_pkg;

  localparam int DATA_W    = 11;
  localparam int LINK_W    = 15;
  localparam int VALID_BIT = 11;
  localparam int ACK_BIT   = 13;

  // Direction codes double as bit indices into the {down,up,right,left} mask.
  localparam logic [1:0] DIR_L = 2'd0;
  localparam logic [1:0] DIR_R = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;
  localparam logic [1:0] DIR_D = 2'd3;

  localparam logic signed [DATA_W-1:0] TIS_MAX = 11'sd999;
  localparam logic signed [DATA_W-1:0] TIS_MIN = -11'sd999;

  typedef logic signed [DATA_W-1:0] tis_word_t;
  typedef logic [LINK_W-1:0]        link_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFER  = 2'd1,
    ST_RETIRE = 2'd2
  } wr_state_t;

  // Saturate a raw word into the TIS-100 value range.
  function automatic tis_word_t tis_clamp(input tis_word_t v);
    if (v > TIS_MAX)      return TIS_MAX;
    else if (v < TIS_MIN) return TIS_MIN;
    else                  return v;
  endfunction

  // Build an outgoing link word: data in the low bits, valid flag, rest zero.
  function automatic link_t link_pack(input tis_word_t d, input logic valid);
    link_t w;
    w                = '0;
    w[DATA_W-1:0]    = d;
    w[VALID_BIT]     = valid;
    return w;
  endfunction

endpackage

// File: rtl/tis_ack_prio.sv
// Combinational 4-way fixed-priority picker: LEFT > RIGHT > UP > DOWN.
// Input bit order is {down,up,right,left}; output is {hit, dir}.
// Shared by the ANY-write and ANY-read paths of a node.
module tis_ack_prio
  import tis_any_writer_pkg::*;
(
  input  logic [3:0] req,
  output logic       hit,
  output logic [1:0] dir
);

  // Lowest-numbered requesting port wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    hit = |req;
    dir = DIR_L;
    if (req[DIR_L])      dir = DIR_L;
    else if (req[DIR_R]) dir = DIR_R;
    else if (req[DIR_U]) dir = DIR_U;
    else if (req[DIR_D]) dir = DIR_D;
  end

endmodule

// File: rtl/tis_any_writer.sv
// Transmit side of a TIS-100 node link: MOV <src>, {UP|DOWN|LEFT|RIGHT|ANY}.
// One value is offered on every masked port; the first masked neighbour to
// ack takes it, the offer is retracted everywhere, and the writer then waits
// for all incoming acks to drop before accepting the next write.
// Optional feature: define TIS_ANY_LAST_EN to keep a last_dir register that
// records which port took each value; otherwise last_dir is tied to zero.
module tis_any_writer
  import tis_any_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        wr_mask,
  output logic              busy,
  output logic              done,
  output logic [1:0]        last_dir,
  output logic [LINK_W-1:0] upOut,
  output logic [LINK_W-1:0] downOut,
  output logic [LINK_W-1:0] leftOut,
  output logic [LINK_W-1:0] rightOut,
  input  logic [LINK_W-1:0] up,
  input  logic [LINK_W-1:0] down,
  input  logic [LINK_W-1:0] left,
  input  logic [LINK_W-1:0] right
);

  wr_state_t  state_q, state_d;
  tis_word_t  data_q;
  logic [3:0] mask_q;
  logic       done_q;
  logic       load;
  logic       take;
  logic [3:0] ack_vec;
  logic       prio_hit;
  logic [1:0] prio_dir;
  link_t      offer_link;

  // Only ACK_BIT of each incoming bus matters to this side of the link.
  assign ack_vec = {down[ACK_BIT], up[ACK_BIT], right[ACK_BIT], left[ACK_BIT]};

  // Acks from ports we are not offering on never count.
  tis_ack_prio u_prio (
    .req (ack_vec & mask_q),
    .hit (prio_hit),
    .dir (prio_dir)
  );

  // Next-state logic: accept in IDLE, complete on the winning ack, then wait
  // for every neighbour to release its ack so a held ack cannot finish the
  // following write.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_req && (wr_mask != 4'b0000)) begin
          load    = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (prio_hit) begin
          take    = 1'b1;
          state_d = ST_RETIRE;
        end
      end
      ST_RETIRE: begin
        if (ack_vec == 4'b0000) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched write operands and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand registers are reset along with the FSM; they are a
    // handful of flops and a clean post-reset value keeps debug traces sane.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state_q <= state_d;
      done_q  <= take;
      if (load) begin
        data_q <= tis_clamp(wr_data);
        mask_q <= wr_mask;
      end
    end
  end

`ifdef TIS_ANY_LAST_EN
  logic [1:0] last_dir_q;

  // Record the port that took the most recent value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_dir_q <= DIR_L;
    else if (take) last_dir_q <= prio_dir;
  end

  assign last_dir = last_dir_q;
`else
  assign last_dir = 2'b00;
`endif

  // The offer is decoded straight from state so reset retracts it at once.
  always_comb begin
    offer_link = link_pack(data_q, 1'b1);
    leftOut    = '0;
    rightOut   = '0;
    upOut      = '0;
    downOut    = '0;
    if (state_q == ST_OFFER) begin
      if (mask_q[DIR_L]) leftOut  = offer_link;
      if (mask_q[DIR_R]) rightOut = offer_link;
      if (mask_q[DIR_U]) upOut    = offer_link;
      if (mask_q[DIR_D]) downOut  = offer_link;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  // Incoming bus bits other than the acks belong to the read path.
  logic unused_link;
  assign unused_link = ^{up, down, left, right, prio_dir};

endmodule

// File: tb/tb_tis_any_writer.sv
// Self-checking bench for tis_any_writer: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// transaction-level model of the link protocol.
module tb_tis_any_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req;
  logic [10:0] wr_data;
  logic [3:0]  wr_mask;
  logic        busy, done;
  logic [1:0]  last_dir;
  logic [14:0] upOut, downOut, leftOut, rightOut;
  logic [14:0] up, down, left, right;

  int errors = 0;
  int checks = 0;

  tis_any_writer dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_data(wr_data),
    .wr_mask(wr_mask), .busy(busy), .done(done), .last_dir(last_dir),
    .upOut(upOut), .downOut(downOut), .leftOut(leftOut), .rightOut(rightOut),
    .up(up), .down(down), .left(left), .right(right)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // last_dir only carries information when the optional register is built.
  function automatic logic [1:0] exp_dir(input logic [1:0] d);
`ifdef TIS_ANY_LAST_EN
    return d;
`else
    return 2'b00;
`endif
  endfunction

  // ---------------- transaction-level model ----------------
  // A write is either outstanding (offered), being retired (waiting for all
  // acks to clear) or absent.
  logic        m_outstanding, m_retiring, m_done;
  logic [1:0]  m_last;
  logic [10:0] m_value;
  logic [3:0]  m_mask;

  function automatic logic [10:0] clamp_val(input logic [10:0] raw);
    int v;
    v = int'($signed(raw));
    if (v > 999)  v = 999;
    if (v < -999) v = -999;
    return v[10:0];
  endfunction

  function automatic int first_taker(input logic [3:0] acks);
    // left, right, up, down: first in that order wins
    for (int p = 0; p < 4; p++) if (acks[p]) return p;
    return -1;
  endfunction

  function automatic logic [14:0] link_word(input logic [10:0] v);
    return {3'b000, 1'b1, v};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_outstanding <= 1'b0;
      m_retiring    <= 1'b0;
      m_done        <= 1'b0;
      m_last        <= 2'd0;
      m_value       <= '0;
      m_mask        <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_outstanding && !m_retiring) begin
        if (wr_req && wr_mask != 4'b0) begin
          m_outstanding <= 1'b1;
          m_value       <= clamp_val(wr_data);
          m_mask        <= wr_mask;
        end
      end else if (m_outstanding) begin
        if (first_taker({down[13], up[13], right[13], left[13]} & m_mask) >= 0) begin
          m_done        <= 1'b1;
          m_last        <= 2'(first_taker({down[13], up[13], right[13], left[13]} & m_mask));
          m_outstanding <= 1'b0;
          m_retiring    <= 1'b1;
        end
      end else begin
        if ({down[13], up[13], right[13], left[13]} == 4'b0) m_retiring <= 1'b0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_outstanding | m_retiring));
    check("done", 32'(done), 32'(m_done));
    check("last_dir", 32'(last_dir), 32'(exp_dir(m_last)));
    check("leftOut",  32'(leftOut),  (m_outstanding && m_mask[0]) ? 32'(link_word(m_value)) : 32'd0);
    check("rightOut", 32'(rightOut), (m_outstanding && m_mask[1]) ? 32'(link_word(m_value)) : 32'd0);
    check("upOut",    32'(upOut),    (m_outstanding && m_mask[2]) ? 32'(link_word(m_value)) : 32'd0);
    check("downOut",  32'(downOut),  (m_outstanding && m_mask[3]) ? 32'(link_word(m_value)) : 32'd0);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acks();
    up = '0; down = '0; left = '0; right = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    rst_n = 1'b0; wr_req = 1'b0; wr_data = '0; wr_mask = '0;
    clear_acks();
    #23;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_outs", 32'(upOut | downOut | leftOut | rightOut), 32'd0);
    check("rst_last", 32'(last_dir), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // 1: single port, ack two cycles after the offer appears
    wr_req = 1'b1; wr_data = 11'd42; wr_mask = 4'b0001;
    tick(); wr_req = 1'b0;
    check("t1_offer", 32'(leftOut), 32'h082A);
    check("t1_others", 32'(upOut | downOut | rightOut), 32'd0);
    tick();
    check("t1_hold", 32'(leftOut), 32'h082A);
    left[13] = 1'b1;
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_dir", 32'(last_dir), 32'(exp_dir(2'd0)));
    check("t1_clear", 32'(leftOut), 32'd0);
    clear_acks();
    tick();
    check("t1_pulse", 32'(done), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // 2: ANY, only down takes
    wr_req = 1'b1; wr_data = 11'd7; wr_mask = 4'b1111;
    tick(); wr_req = 1'b0;
    check("t2_all", 32'(upOut & downOut & leftOut & rightOut), 32'h0807);
    down[13] = 1'b1;
    tick();
    check("t2_done", 32'(done), 32'd1);
    check("t2_dir", 32'(last_dir), 32'(exp_dir(2'd3)));
    check("t2_drop", 32'(upOut | downOut | leftOut | rightOut), 32'd0);
    clear_acks(); tick();

    // 3: up and right ack together -> RIGHT wins, one done
    wr_req = 1'b1; wr_data = 11'd100; wr_mask = 4'b1111;
    tick(); wr_req = 1'b0;
    up[13] = 1'b1; right[13] = 1'b1;
    dones = 0;
    tick();
    if (done) dones++;
    check("t3_dir", 32'(last_dir), 32'(exp_dir(2'd1)));
    tick(); if (done) dones++;
    clear_acks();
    tick(); if (done) dones++;
    check("t3_once", 32'(dones), 32'd1);

    // 4: clamping at both ends
    wr_req = 1'b1; wr_data = 11'd1023; wr_mask = 4'b0001;
    tick(); wr_req = 1'b0;
    check("t4_hi", 32'(leftOut), 32'h0BE7);
    left[13] = 1'b1; tick(); clear_acks(); tick();
    wr_req = 1'b1; wr_data = 11'h400; wr_mask = 4'b0001;
    tick(); wr_req = 1'b0;
    check("t4_lo", 32'(leftOut), 32'h0C19);
    left[13] = 1'b1; tick(); clear_acks(); tick();

    // 5: held ack blocks the next write until released
    wr_req = 1'b1; wr_data = 11'd5; wr_mask = 4'b0001;
    tick();
    left[13] = 1'b1; wr_data = 11'd9;
    tick();
    check("t5_take", 32'(done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_blocked", 32'(leftOut), 32'd0);
      check("t5_busy", 32'(busy), 32'd1);
    end
    clear_acks();
    tick();
    check("t5_still", 32'(leftOut), 32'd0);
    tick(); wr_req = 1'b0;
    check("t5_resume", 32'(leftOut), 32'h0809);
    left[13] = 1'b1; tick();
    check("t5_done2", 32'(done), 32'd1);
    clear_acks(); tick();

    // 6: reset while the offer is up
    wr_req = 1'b1; wr_data = 11'd3; wr_mask = 4'b0001;
    tick(); wr_req = 1'b0;
    check("t6_up", 32'(leftOut), 32'h0803);
    #2; rst_n = 1'b0; #1;
    check("t6_outs", 32'(leftOut), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    left[13] = 1'b1;
    tick();
    check("t6_nodone", 32'(done), 32'd0);
    check("t6_last", 32'(last_dir), 32'd0);
    rst_n = 1'b1; clear_acks(); tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      wr_req  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       wr_data = 11'h3FF;
        1:       wr_data = 11'h400;
        default: wr_data = 11'($urandom);
      endcase
      wr_mask = 4'($urandom_range(0, 15));
      up    = 15'($urandom); up[13]    = ($urandom_range(0, 3) == 0);
      down  = 15'($urandom); down[13]  = ($urandom_range(0, 3) == 0);
      left  = 15'($urandom); left[13]  = ($urandom_range(0, 3) == 0);
      right = 15'($urandom); right[13] = ($urandom_range(0, 3) == 0);
      tick();
    end
    clear_acks(); wr_req = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
